dyn_add_ctrl: RTL and testbench
===============================

# dyn_add_ctrl

Sequencing controller for the shared N-bit combinational ripple-carry adder. Accepts one operand set at a time over a valid/ready handshake, drives the adder's inputs from registers, and waits a data-dependent number of clock cycles derived from the longest carry-propagate run before capturing the result. It is the completion-timing front end that turns the gate-delay-bound adder into a variable-latency, clocked functional unit.

## Interface
- N, 16, operand width; must match the attached adder
- K, 4, bit positions the carry is guaranteed to ripple per clock period; legal range 1..N
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand set offered
- in_ready  out  1  controller can accept an operand set
- in_a, in_b  in  N  operands
- in_cin  in  1  carry in
- rca_a, rca_b  out  N  registered adder operands
- rca_cin  out  1  registered adder carry in
- rca_s  in  N  adder sum
- rca_cout  in  1  adder carry out
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  N+1  captured {carry out, sum}
- out_cycles  out  clog2(N/K+2)  wait cycles spent on this result

## Operation
- Longest run L = maximum count of consecutive 1s in in_a ^ in_b, range 0..N, evaluated combinationally on the accept cycle.
- Wait count W = 1 + floor(L / K); range 1..N/K+1.
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid: load rca_a/rca_b/rca_cin from inputs, load counter with W, set out_cycles = W, go to RUN.
- RUN: in_ready = 0. The counter decrements each cycle. When the counter equals 1, capture {rca_cout, rca_s} into out_sum, set out_valid, and go to DONE.
- DONE: out_valid = 1 with out_sum stable. On out_ready, clear out_valid and go to IDLE.
- rca_* hold their values from accept until the next accept; they are never changed during RUN.
- in_valid outside IDLE is ignored and not queued. Upstream must hold its data until it sees in_ready.
- Only one transaction is outstanding at a time.
- The block has no internal sum arithmetic. out_sum is exactly the adder's output, sampled at the scheduled edge.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_sum 0, out_cycles 0, rca_a 0, rca_b 0, rca_cin 0, counter 0.
- Accept at edge t: rca_* are valid after t. The result is captured at edge t+W, and out_valid is high from t+W.
- Minimum accept-to-accept interval is W+2 cycles, with out_ready held high.
- out_ready may be high before out_valid. DONE then lasts exactly one cycle.
- Reset asserted in RUN or DONE aborts the transaction immediately and asynchronously. All outputs return to their reset values. No result is emitted after release.
- Reset deasserts synchronously to clk at the boundary.
- L = N (all-propagate) gives the maximum W. L = 0 gives W = 1.

## Structure
- Package dyn_add_pkg holds:
  - the state encoding (IDLE/RUN/DONE)
  - a constant function for the counter width, clog2(N/K+2)
  - a constant function for the L width, clog2(N+1)
- Sub-module carry_chain_len: purely combinational, N-bit vector in, longest run of 1s out. It is instantiated once on in_a ^ in_b.
- The controller holds the FSM, counter, operand registers and result register.
- The ripple-carry adder is instantiated beside the controller, not inside it.

## Test plan
- Reset, then A=0x0000, B=0x0000, Cin=0 -> L=0, W=1; out_valid one cycle after accept; out_sum=0x00000, out_cycles=1.
- A=0x00F0, B=0x000F, Cin=0 -> L=8, W=3; out_sum=0x000FF at accept+3.
- A=0xFFFF, B=0x0000, Cin=1 -> L=16, W=5; out_sum=0x10000, out_cycles=5.
- Hold out_ready=0 for 4 cycles after out_valid -> out_sum/out_valid stable, in_ready=0, extra in_valid pulse ignored; release -> IDLE next cycle.
- Assert rst_n low two cycles into a W=5 RUN -> outputs at reset values immediately; no out_valid after release; next transaction correct.
- 10000 random operand sets with random out_ready back-pressure against the real adder model (gate delays K bits per clock) -> every out_sum equals A+B+Cin and out_cycles equals 1+floor(L/K).

Source files
------------

// File: rtl/dyn_add_pkg.sv
// dyn_add_pkg: shared state encoding and width helpers for the variable-latency adder controller
package dyn_add_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int cnt_w(input int n, input int k);
      return $clog2(n / k + 2);
   endfunction
   function automatic int len_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/carry_chain_len.sv
// carry_chain_len: longest run of consecutive ones in a vector, purely combinational
module carry_chain_len
   import dyn_add_pkg::*;
#(
   parameter int N = 16,
   localparam int LW = len_w(N)
) (
   input  logic [N-1:0]  v,
   output logic [LW-1:0] len
);
   logic [LW-1:0] run;
   always_comb begin
      run = '0;
      len = '0;
      for (int i = 0; i < N; i++) begin
         run = v[i] ? run + LW'(1) : '0;
         len = run > len ? run : len;
      end
   end
endmodule

// File: rtl/dyn_add_ctrl.sv
// dyn_add_ctrl: sequences a shared ripple-carry adder, waiting 1+floor(L/K) cycles
// where L is the longest propagate run of the accepted operands
module dyn_add_ctrl
   import dyn_add_pkg::*;
#(
   parameter int N = 16,
   parameter int K = 4,
   localparam int CW = cnt_w(N, K),
   localparam int LW = len_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [N-1:0]  in_b,
   input  logic          in_cin,
   output logic [N-1:0]  rca_a,
   output logic [N-1:0]  rca_b,
   output logic          rca_cin,
   input  logic [N-1:0]  rca_s,
   input  logic          rca_cout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N:0]    out_sum,
   output logic [CW-1:0] out_cycles
);
   state_t        state, nxt;
   logic [CW-1:0] cnt, w;
   logic [LW-1:0] run_len;
   logic          accept, capture;
   carry_chain_len #(.N(N)) u_len (.v(in_a ^ in_b), .len(run_len));
   assign w         = CW'(run_len / LW'(K)) + CW'(1);
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_ready && in_valid;
   assign capture   = state == RUN && cnt == CW'(1);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = in_valid ? RUN : IDLE;
         RUN:     nxt = capture ? DONE : RUN;
         DONE:    nxt = out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rca_a      <= '0;
         rca_b      <= '0;
         rca_cin    <= 1'b0;
         cnt        <= '0;
         out_sum    <= '0;
         out_cycles <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            rca_a      <= in_a;
            rca_b      <= in_b;
            rca_cin    <= in_cin;
            cnt        <= w;
            out_cycles <= w;
         end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
         end
         if (capture) out_sum <= {rca_cout, rca_s};
      end
   end
endmodule

// File: tb/tb_dyn_add_ctrl.sv
// tb_dyn_add_ctrl: directed table plus random checks against a K-bits-per-cycle adder model
module tb_dyn_add_ctrl;
   localparam int N = 16;
   localparam int K = 4;
   logic          clk = 0, rst_n = 0;
   logic          in_valid = 0, in_cin = 0, out_ready = 0;
   logic [N-1:0]  in_a = 0, in_b = 0;
   logic          in_ready, rca_cin, rca_cout, out_valid;
   logic [N-1:0]  rca_a, rca_b, rca_s;
   logic [N:0]    out_sum, true_s;
   logic [2:0]    out_cycles;
   logic [2*N:0]  prev = '0;
   int            age = 0, lm, total = 0, passed = 0;

   typedef struct {
      logic [N-1:0] a, b;
      logic         cin;
      logic [N:0]   sum;
      int           cyc;
   } vec_t;
   vec_t vt[9];

   always #5 clk = ~clk;

   dyn_add_ctrl #(.N(N), .K(K)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
      .rca_s(rca_s), .rca_cout(rca_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cycles(out_cycles)
   );

   function automatic int runlen(input logic [N-1:0] v);
      int r = 0, m = 0;
      for (int i = 0; i < N; i++) begin
         r = v[i] ? r + 1 : 0;
         if (r > m) m = r;
      end
      return m;
   endfunction

   // adder output is wrong until the carry has had time to ripple across the longest run
   assign true_s = {1'b0, rca_a} + {1'b0, rca_b} + {{N{1'b0}}, rca_cin};
   always_comb lm = runlen(rca_a ^ rca_b);
   assign {rca_cout, rca_s} = (age * K > lm) ? true_s : true_s ^ {{N{1'b0}}, 1'b1};
   always @(negedge clk) begin
      if ({rca_a, rca_b, rca_cin} != prev) begin
         prev = {rca_a, rca_b, rca_cin};
         age = 1;
      end else if (age < 1000) age++;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic txn(input logic [N-1:0] a, b, input logic c, input logic [N:0] es,
                      input int ec, input int bp, input bit poke, input string nm);
      int lat;
      out_ready = (bp < 0);
      in_a = a; in_b = b; in_cin = c; in_valid = 1;
      chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, lat, ec);
      chk({nm, "_sum"}, out_sum, es);
      chk({nm, "_cycles"}, out_cycles, ec);
      if (bp < 0) begin
         @(negedge clk);
         chk({nm, "_done_1cyc"}, out_valid, 0);
      end else begin
         for (int i = 0; i < bp; i++) begin
            in_valid = poke && i == 0;
            in_a = ~a;
            @(negedge clk);
            in_valid = 0;
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_sum"}, out_sum, es);
            chk({nm, "_hold_ready"}, in_ready, 0);
         end
         if (poke) chk({nm, "_rca_kept"}, rca_a, a);
         out_ready = 1;
         @(negedge clk);
         out_ready = 0;
         chk({nm, "_release_valid"}, out_valid, 0);
         chk({nm, "_release_ready"}, in_ready, 1);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_in_ready"}, in_ready, 1);
      chk({nm, "_out_valid"}, out_valid, 0);
      chk({nm, "_out_sum"}, out_sum, 0);
      chk({nm, "_out_cycles"}, out_cycles, 0);
      chk({nm, "_rca"}, {rca_a, rca_b, rca_cin}, 0);
   endtask

   initial begin
      logic [N-1:0] a, b;
      logic         c;
      vt[0] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 1};
      vt[1] = '{16'h00F0, 16'h000F, 1'b0, 17'h000FF, 3};
      vt[2] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000, 5};
      vt[3] = '{16'h5555, 16'hAAAA, 1'b0, 17'h0FFFF, 5};
      vt[4] = '{16'h0001, 16'h0001, 1'b0, 17'h00002, 1};
      vt[5] = '{16'h000F, 16'h0000, 1'b0, 17'h0000F, 2};
      vt[6] = '{16'h0007, 16'h0000, 1'b0, 17'h00007, 1};
      vt[7] = '{16'h8000, 16'h8000, 1'b1, 17'h10001, 1};
      vt[8] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000, 3};
      #1 chk_reset("reset");
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < 9; i++)
         txn(vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cyc, 0, 0, $sformatf("vec%0d", i));
      txn(vt[1].a, vt[1].b, vt[1].cin, vt[1].sum, vt[1].cyc, 4, 1, "hold");
      txn(vt[8].a, vt[8].b, vt[8].cin, vt[8].sum, vt[8].cyc, -1, 0, "preready");
      // abort a W=5 run two cycles in
      out_ready = 0;
      in_a = 16'hFFFF; in_b = 16'h0000; in_cin = 1; in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      rst_n = 0;
      #1 chk_reset("abort");
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_result", out_valid, 0);
      end
      txn(vt[2].a, vt[2].b, vt[2].cin, vt[2].sum, vt[2].cyc, 0, 0, "after_abort");
      for (int i = 0; i < 10000; i++) begin
         a = 16'($urandom);
         b = (i % 4 == 0) ? ~a ^ 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
         c = 1'($urandom);
         txn(a, b, c, {1'b0, a} + {1'b0, b} + {16'b0, c}, 1 + runlen(a ^ b) / K,
             int'($urandom_range(0, 3)) - 1, 0, "rand");
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
